// File: rtl/pwm_multicanal.sv
// Multi-channel PWM generator sharing one period counter. Period, mode and duty
// writes land in shadow registers and are committed to the active set only at a
// period boundary (or every cycle while disabled), so no partial periods appear.
module pwm_multicanal #(
    parameter int unsigned CANAIS          = 4,
    parameter int unsigned LARGURA         = 16,
    parameter int unsigned PERIODO_DEFAULT = 1250
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic                                           enable,
    input  logic                                           modo_centro,
    input  logic                                           periodo_wr,
    input  logic [LARGURA-1:0]                             periodo_in,
    input  logic                                           duty_wr,
    input  logic [((CANAIS > 1) ? $clog2(CANAIS) : 1)-1:0] duty_canal,
    input  logic [LARGURA-1:0]                             duty_in,
    output logic [CANAIS-1:0]                              pwm,
    output logic                                           fim_periodo
);

    localparam int unsigned IdxW = (CANAIS > 1) ? $clog2(CANAIS) : 1;
    localparam logic [LARGURA-1:0] PerDef = LARGURA'(PERIODO_DEFAULT);
    localparam logic [LARGURA-1:0] PerMin = LARGURA'(2);

    typedef enum logic {DirUp, DirDown} dir_e;

    logic [LARGURA-1:0] cnt_q, cnt_d;
    dir_e               dir_q, dir_d;
    logic               enable_q;

    logic [LARGURA-1:0] periodo_sh_q, periodo_sh_d;
    logic [LARGURA-1:0] periodo_at_q, periodo_at_d;
    logic               modo_sh_q;
    logic               modo_at_q, modo_at_d;
    logic [LARGURA-1:0] duty_sh_q [CANAIS];
    logic [LARGURA-1:0] duty_sh_d [CANAIS];
    logic [LARGURA-1:0] duty_at_q [CANAIS];
    logic [LARGURA-1:0] duty_at_d [CANAIS];

    logic [CANAIS-1:0]  pwm_q, pwm_d;
    logic               fim_q, fim_d;

    logic [LARGURA-1:0] ultimo;
    logic               fronteira;
    logic               commit;
    logic               troca_modo;

    // Boundary detection and commit qualification from the active registers.
    always_comb begin
        ultimo    = periodo_at_q - LARGURA'(1);
        fronteira = 1'b0;
        if (enable) begin
            if (!modo_at_q) begin
                fronteira = (cnt_q >= ultimo);
            end else begin
                // First enabled cycle also opens a centre-aligned period.
                fronteira = ((cnt_q == '0) && (dir_q == DirDown)) || !enable_q;
            end
        end
        commit     = !enable || fronteira;
        troca_modo = commit && (modo_sh_q != modo_at_q);
    end

    // Shadow writes and shadow-to-active commit with period clamp.
    always_comb begin
        periodo_sh_d = periodo_wr ? periodo_in : periodo_sh_q;
        periodo_at_d = periodo_at_q;
        modo_at_d    = modo_at_q;
        for (int i = 0; i < int'(CANAIS); i++) begin
            duty_sh_d[i] = duty_sh_q[i];
            duty_at_d[i] = duty_at_q[i];
            if (duty_wr && (duty_canal == IdxW'(i))) begin
                duty_sh_d[i] = duty_in;
            end
        end
        if (commit) begin
            periodo_at_d = (periodo_sh_q < PerMin) ? PerMin : periodo_sh_q;
            modo_at_d    = modo_sh_q;
            for (int i = 0; i < int'(CANAIS); i++) begin
                duty_at_d[i] = duty_sh_q[i];
            end
        end
    end

    // Period counter: edge mode wraps, centre mode bounces between 0 and P-1.
    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!enable || troca_modo) begin
            cnt_d = '0;
            dir_d = DirUp;
        end else if (!modo_at_q) begin
            cnt_d = fronteira ? '0 : cnt_q + LARGURA'(1);
            dir_d = DirUp;
        end else if ((dir_q == DirUp) && (cnt_q >= ultimo)) begin
            cnt_d = cnt_q - LARGURA'(1);
            dir_d = DirDown;
        end else if ((dir_q == DirDown) && (cnt_q == '0)) begin
            cnt_d = LARGURA'(1);
            dir_d = DirUp;
        end else if (dir_q == DirUp) begin
            cnt_d = cnt_q + LARGURA'(1);
        end else begin
            cnt_d = cnt_q - LARGURA'(1);
        end
    end

    // Output compare against the duty values active during this cycle.
    always_comb begin
        for (int i = 0; i < int'(CANAIS); i++) begin
            pwm_d[i] = enable && (cnt_q < duty_at_q[i]);
        end
        fim_d = fronteira;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            dir_q        <= DirUp;
            enable_q     <= 1'b0;
            periodo_sh_q <= PerDef;
            periodo_at_q <= PerDef;
            modo_sh_q    <= 1'b0;
            modo_at_q    <= 1'b0;
            for (int i = 0; i < int'(CANAIS); i++) begin
                duty_sh_q[i] <= '0;
                duty_at_q[i] <= '0;
            end
            pwm_q        <= '0;
            fim_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            enable_q     <= enable;
            periodo_sh_q <= periodo_sh_d;
            periodo_at_q <= periodo_at_d;
            modo_sh_q    <= modo_centro;
            modo_at_q    <= modo_at_d;
            for (int i = 0; i < int'(CANAIS); i++) begin
                duty_sh_q[i] <= duty_sh_d[i];
                duty_at_q[i] <= duty_at_d[i];
            end
            pwm_q        <= pwm_d;
            fim_q        <= fim_d;
        end
    end

    assign pwm         = pwm_q;
    assign fim_periodo = fim_q;

endmodule

// File: tb/tb_pwm_multicanal.sv
// Bench for pwm_multicanal: a vector table, hand-written corner sequences and a
// randomized run checked against a phase-position reference model.
module tb_pwm_multicanal;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        modo_centro;
    logic        periodo_wr;
    logic [15:0] periodo_in;
    logic        duty_wr;
    logic [1:0]  duty_canal;
    logic [15:0] duty_in;
    logic [3:0]  pwm;
    logic        fim_periodo;
    logic [2:0]  pwm3;
    logic        fim3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pwm_multicanal #(.CANAIS(4), .LARGURA(16), .PERIODO_DEFAULT(1250)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .modo_centro (modo_centro),
        .periodo_wr  (periodo_wr),
        .periodo_in  (periodo_in),
        .duty_wr     (duty_wr),
        .duty_canal  (duty_canal),
        .duty_in     (duty_in),
        .pwm         (pwm),
        .fim_periodo (fim_periodo)
    );

    // Three-channel copy: index 3 is out of range there and must be ignored.
    pwm_multicanal #(.CANAIS(3), .LARGURA(16), .PERIODO_DEFAULT(1250)) dut3 (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .modo_centro (modo_centro),
        .periodo_wr  (periodo_wr),
        .periodo_in  (periodo_in),
        .duty_wr     (duty_wr),
        .duty_canal  (duty_canal),
        .duty_in     (duty_in),
        .pwm         (pwm3),
        .fim_periodo (fim3)
    );

    // Reference model: position inside the current period, not an up/down counter.
    int m_psh, m_pat, m_pos;
    int m_dsh [4];
    int m_dat [4];
    bit m_msh, m_mat, m_quiet;

    function automatic void model_reset();
        m_psh = 1250; m_pat = 1250; m_msh = 0; m_mat = 0;
        m_pos = 0; m_quiet = 0;
        for (int i = 0; i < 4; i++) begin
            m_dsh[i] = 0; m_dat[i] = 0;
        end
    endfunction

    function automatic void model_commit();
        m_pat = (m_psh < 2) ? 2 : m_psh;
        m_mat = m_msh;
        for (int i = 0; i < 4; i++) m_dat[i] = m_dsh[i];
    endfunction

    function automatic void model_step(output logic [3:0] ep, output logic ef);
        int p, c, len;
        bit bnd, old_m;
        p = m_pat; ep = '0; ef = 1'b0;
        if (!enable) begin
            model_commit();
            m_pos = 0; m_quiet = 0;
        end else begin
            c = (m_mat && m_pos > p - 1) ? 2 * p - 2 - m_pos : m_pos;
            bnd = m_mat ? (m_pos == 0 && !m_quiet) : (m_pos == p - 1);
            for (int i = 0; i < 4; i++) ep[i] = (c < m_dat[i]);
            ef = bnd;
            old_m = m_mat;
            if (bnd) model_commit();
            if (bnd && m_mat != old_m) begin
                m_pos = 0; m_quiet = 1;
            end else if (bnd && !old_m) begin
                m_pos = 0; m_quiet = 0;
            end else begin
                len = m_mat ? 2 * m_pat - 2 : m_pat;
                m_pos = (m_pos + 1) % len; m_quiet = 0;
            end
        end
        if (periodo_wr) m_psh = int'(periodo_in);
        if (duty_wr) m_dsh[duty_canal] = int'(duty_in);
        m_msh = modo_centro;
    endfunction

    task automatic check(input string name, input logic [3:0] gp, input logic gf,
                         input logic [3:0] wp, input logic wf);
        vectors++;
        if (gp !== wp || gf !== wf) begin
            miscompares++;
            $display("FAIL %s @%0t: pwm=%b fim=%b, required pwm=%b fim=%b",
                     name, $time, gp, gf, wp, wf);
        end
    endtask

    // One clock with the given inputs; both DUTs are compared with the model.
    task automatic cyc(input logic en, input logic md, input logic pwr, input logic [15:0] pin,
                       input logic dwr, input logic [1:0] dch, input logic [15:0] din,
                       output logic [3:0] ep, output logic ef);
        enable = en; modo_centro = md; periodo_wr = pwr; periodo_in = pin;
        duty_wr = dwr; duty_canal = dch; duty_in = din;
        model_step(ep, ef);
        @(posedge clock);
        #1;
        check("modelo", pwm, fim_periodo, ep, ef);
        check("modelo3", {1'b0, pwm3}, fim3, {1'b0, ep[2:0]}, ef);
        periodo_wr = 1'b0; duty_wr = 1'b0;
    endtask

    task automatic pulse_reset();
        enable = 1'b0; periodo_wr = 1'b0; duty_wr = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        en;
        logic        pwr;
        logic [15:0] pin;
        logic        dwr;
        logic [1:0]  dch;
        logic [15:0] din;
        logic [3:0]  pwm;
        logic        fim;
    } vec_t;

    function automatic vec_t mk(logic en, logic pwr, logic [15:0] pin, logic dwr,
                                logic [1:0] dch, logic [15:0] din, logic [3:0] p, logic f);
        vec_t v;
        v.en = en; v.pwr = pwr; v.pin = pin; v.dwr = dwr; v.dch = dch; v.din = din;
        v.pwm = p; v.fim = f;
        return v;
    endfunction

    initial begin
        vec_t tbl [18];
        logic [3:0] ep;
        logic ef;
        int   pat [6];
        int   dq [4];
        int   c;
        logic md;

        // Edge mode P=10, duties 3/0/10/7 programmed while disabled.
        tbl[0]  = mk(0, 1, 16'd10, 0, 2'd0, 16'd0,  4'h0, 0);
        tbl[1]  = mk(0, 0, 16'd0,  1, 2'd0, 16'd3,  4'h0, 0);
        tbl[2]  = mk(0, 0, 16'd0,  1, 2'd1, 16'd0,  4'h0, 0);
        tbl[3]  = mk(0, 0, 16'd0,  1, 2'd2, 16'd10, 4'h0, 0);
        tbl[4]  = mk(0, 0, 16'd0,  1, 2'd3, 16'd7,  4'h0, 0);
        tbl[5]  = mk(0, 0, 16'd0,  0, 2'd0, 16'd0,  4'h0, 0);
        tbl[6]  = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hD, 0);
        tbl[7]  = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hD, 0);
        tbl[8]  = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hD, 0);
        tbl[9]  = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hC, 0);
        tbl[10] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hC, 0);
        tbl[11] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hC, 0);
        tbl[12] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hC, 0);
        tbl[13] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'h4, 0);
        tbl[14] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'h4, 0);
        tbl[15] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'h4, 1);
        tbl[16] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hD, 0);
        tbl[17] = mk(1, 0, 16'd0,  0, 2'd0, 16'd0,  4'hD, 0);
        pat = '{1, 1, 0, 0, 0, 1};

        reset = 1'b1; enable = 1'b0; modo_centro = 1'b0; periodo_wr = 1'b0;
        periodo_in = '0; duty_wr = 1'b0; duty_canal = '0; duty_in = '0;
        #1;
        check("reset", pwm, fim_periodo, 4'h0, 1'b0);
        check("reset3", {1'b0, pwm3}, fim3, 4'h0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        for (int k = 0; k < 18; k++) begin
            cyc(tbl[k].en, 0, tbl[k].pwr, tbl[k].pin, tbl[k].dwr, tbl[k].dch, tbl[k].din, ep, ef);
            check("tabela", pwm, fim_periodo, tbl[k].pwm, tbl[k].fim);
        end

        // Centre mode P=4, ch0 duty 2.
        pulse_reset();
        cyc(0, 1, 1, 16'd4, 0, 2'd0, 16'd0, ep, ef);
        cyc(0, 1, 0, 16'd0, 1, 2'd0, 16'd2, ep, ef);
        cyc(0, 1, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        cyc(0, 1, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        for (int j = 0; j < 13; j++) begin
            cyc(1, 1, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
            check("centro", {3'b0, pwm[0]}, fim_periodo, {3'b0, pat[j % 6] == 1}, (j % 6) == 0);
        end

        // Duty change mid-period and on the boundary edge.
        pulse_reset();
        cyc(0, 0, 1, 16'd10, 0, 2'd0, 16'd0, ep, ef);
        cyc(0, 0, 0, 16'd0, 1, 2'd0, 16'd3, ep, ef);
        cyc(0, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        dq = '{3, 8, 8, 2};
        for (int j = 0; j < 40; j++) begin
            c = j % 10;
            if (j == 4) cyc(1, 0, 0, 16'd0, 1, 2'd0, 16'd8, ep, ef);
            else if (j == 19) cyc(1, 0, 0, 16'd0, 1, 2'd0, 16'd2, ep, ef);
            else cyc(1, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
            check("duty_troca", {3'b0, pwm[0]}, fim_periodo, {3'b0, c < dq[j / 10]}, c == 9);
        end

        // Period 1 clamps to 2; duty 0xFFFF is constant high.
        pulse_reset();
        cyc(0, 0, 1, 16'd1, 0, 2'd0, 16'd0, ep, ef);
        cyc(0, 0, 0, 16'd0, 1, 2'd0, 16'd1, ep, ef);
        cyc(0, 0, 0, 16'd0, 1, 2'd1, 16'hFFFF, ep, ef);
        cyc(0, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        for (int j = 0; j < 8; j++) begin
            cyc(1, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
            check("periodo_min", {2'b0, pwm[1:0]}, fim_periodo,
                  {2'b0, 1'b1, (j % 2) == 0}, (j % 2) == 1);
        end

        // Out-of-range channel on the 3-channel copy changes nothing there.
        pulse_reset();
        cyc(0, 0, 0, 16'd0, 1, 2'd3, 16'd5, ep, ef);
        cyc(0, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        for (int j = 0; j < 6; j++) begin
            cyc(1, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
            check("canal_invalido", {pwm[3], pwm3}, fim3, {j < 5, 3'b000}, 1'b0);
        end

        // Asynchronous reset while ch0 is high, then default period and duties.
        pulse_reset();
        cyc(0, 0, 1, 16'd10, 0, 2'd0, 16'd0, ep, ef);
        cyc(0, 0, 0, 16'd0, 1, 2'd0, 16'd5, ep, ef);
        cyc(0, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        cyc(1, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        cyc(1, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
        check("antes_reset", {3'b0, pwm[0]}, fim_periodo, 4'h1, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("reset_async", pwm, fim_periodo, 4'h0, 1'b0);
        @(posedge clock);
        #1;
        check("reset_mantido", pwm, fim_periodo, 4'h0, 1'b0);
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < 1260; j++) begin
            cyc(1, 0, 0, 16'd0, 0, 2'd0, 16'd0, ep, ef);
            check("pos_reset", pwm, fim_periodo, 4'h0, j == 1249);
        end

        // Randomized traffic against the model.
        pulse_reset();
        md = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            logic        en, pwr, dwr;
            logic [15:0] pin, din;
            logic [1:0]  dch;
            if ($urandom_range(0, 149) == 0) md = ~md;
            en  = ($urandom_range(0, 24) != 0);
            pwr = ($urandom_range(0, 29) == 0);
            pin = 16'($urandom_range(0, 24));
            dwr = ($urandom_range(0, 3) == 0);
            dch = 2'($urandom_range(0, 3));
            din = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 26));
            cyc(en, md, pwr, pin, dwr, dch, din, ep, ef);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
